// File: rtl/uart_fifo_core.sv
// UART with baud generator, per-direction FIFOs, error flags and runtime echo.
// Define UART_PARITY_EN to add a parity bit to both directions (PARITY_ODD picks the sense).

module uart_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic         do_push, do_pop;

    // The extra pointer MSB separates full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = wptr_q + (AW+1)'(do_push);
        rptr_d  = rptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end
endmodule

module uart_fifo_core #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 325,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    output logic                 Tx,
    input  logic [DATA_BITS-1:0] TxData,
    input  logic                 TxWr,
    output logic                 TxFull,
    output logic                 TxBusy,
    output logic [DATA_BITS-1:0] RxData,
    input  logic                 RxRd,
    output logic                 RxEmpty,
    input  logic                 EchoEn,
    output logic                 FrameErr,
    output logic                 ParityErr,
    output logic                 Overrun
);
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
                           S_PARITY = 3'd3, S_STOP = 3'd4;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [3:0] HALF_BIT = 4'd7, FULL_BIT = 4'd15;
    localparam logic       PAR_ODD  = (PARITY_ODD != 0);

    logic [CW-1:0] baud_q, baud_d;
    logic          tick;
    logic          rx_meta_q, rx_sync_q;
    logic [2:0]    rx_state_q, rx_state_d, tx_state_q, tx_state_d;
    logic [3:0]    rx_tcnt_q, rx_tcnt_d, tx_tcnt_q, tx_tcnt_d;
    logic [2:0]    rx_bcnt_q, rx_bcnt_d, tx_bcnt_q, tx_bcnt_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, tx_head, tx_wdata;
    logic          rx_par_q, rx_par_d, tx_par_q, tx_par_d;
    logic          tx_q, tx_d;
    logic          frame_err_q, frame_err_d, par_err_q, par_err_d, overrun_q, overrun_d;
    logic          rx_done, rx_par_bad, rx_good, rx_full, tx_full, tx_empty, tx_push, tx_pop;

    always_comb begin
        tick   = (baud_q == CW'(CLK_DIV - 1));
        baud_d = tick ? '0 : baud_q + 1'b1;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            S_IDLE: if (tick && !rx_sync_q) begin
                rx_state_d = S_START;
                rx_tcnt_d  = '0;
            end
            S_START: if (tick) begin
                if (rx_tcnt_q == HALF_BIT) begin
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                    rx_tcnt_d  = '0;
                    rx_bcnt_d  = '0;
                end else rx_tcnt_d = rx_tcnt_q + 4'd1;
            end
            S_DATA: if (tick) begin
                if (rx_tcnt_q == FULL_BIT) begin
                    rx_tcnt_d  = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bcnt_q == LAST_BIT) rx_state_d = PAR_EN ? S_PARITY : S_STOP;
                    else rx_bcnt_d = rx_bcnt_q + 3'd1;
                end else rx_tcnt_d = rx_tcnt_q + 4'd1;
            end
            S_PARITY: if (tick) begin
                if (rx_tcnt_q == FULL_BIT) begin
                    rx_tcnt_d  = '0;
                    rx_par_d   = rx_sync_q;
                    rx_state_d = S_STOP;
                end else rx_tcnt_d = rx_tcnt_q + 4'd1;
            end
            S_STOP: if (tick) begin
                if (rx_tcnt_q == FULL_BIT) begin
                    rx_tcnt_d  = '0;
                    rx_done    = 1'b1;
                    rx_state_d = S_IDLE;
                end else rx_tcnt_d = rx_tcnt_q + 4'd1;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // A finished frame is good only with a high stop bit and matching parity.
    always_comb begin
        rx_par_bad  = PAR_EN && (rx_par_q != ((^rx_shift_q) ^ PAR_ODD));
        rx_good     = rx_done && rx_sync_q && !rx_par_bad;
        frame_err_d = rx_done && !rx_sync_q;
        par_err_d   = rx_done && rx_par_bad;
        overrun_d   = rx_good && (rx_full || (EchoEn && tx_full));
        tx_push     = EchoEn ? rx_good : TxWr;
        tx_wdata    = EchoEn ? rx_shift_q : TxData;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: if (tick && !tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_head;
                tx_par_d   = (^tx_head) ^ PAR_ODD;
                tx_state_d = S_START;
                tx_tcnt_d  = '0;
            end
            S_START, S_PARITY, S_STOP: if (tick) begin
                if (tx_tcnt_q == FULL_BIT) begin
                    tx_tcnt_d  = '0;
                    tx_bcnt_d  = '0;
                    tx_state_d = (tx_state_q == S_START) ? S_DATA :
                                 (tx_state_q == S_PARITY) ? S_STOP : S_IDLE;
                end else tx_tcnt_d = tx_tcnt_q + 4'd1;
            end
            S_DATA: if (tick) begin
                if (tx_tcnt_q == FULL_BIT) begin
                    tx_tcnt_d = '0;
                    if (tx_bcnt_q == LAST_BIT) tx_state_d = PAR_EN ? S_PARITY : S_STOP;
                    else begin
                        tx_bcnt_d  = tx_bcnt_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end else tx_tcnt_d = tx_tcnt_q + 4'd1;
            end
            default: tx_state_d = S_IDLE;
        endcase
        case (tx_state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_shift_d[0];
            S_PARITY: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            baud_q      <= '0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_tcnt_q   <= '0;
            rx_bcnt_q   <= '0;
            tx_state_q  <= S_IDLE;
            tx_tcnt_q   <= '0;
            tx_bcnt_q   <= '0;
            tx_q        <= 1'b1;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            baud_q      <= baud_d;
            rx_meta_q   <= Rx;
            rx_sync_q   <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_tcnt_q   <= rx_tcnt_d;
            rx_bcnt_q   <= rx_bcnt_d;
            tx_state_q  <= tx_state_d;
            tx_tcnt_q   <= tx_tcnt_d;
            tx_bcnt_q   <= tx_bcnt_d;
            tx_q        <= tx_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge Clk) begin
        rx_shift_q <= rx_shift_d;
        rx_par_q   <= rx_par_d;
        tx_shift_q <= tx_shift_d;
        tx_par_q   <= tx_par_d;
    end

    uart_sync_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(Clk), .rst(Rst), .push(rx_good), .pop(RxRd), .wdata(rx_shift_q),
        .rdata(RxData), .full(rx_full), .empty(RxEmpty)
    );

    uart_sync_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(Clk), .rst(Rst), .push(tx_push), .pop(tx_pop), .wdata(tx_wdata),
        .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    assign Tx        = tx_q;
    assign TxFull    = tx_full;
    assign TxBusy    = (tx_state_q != S_IDLE);
    assign FrameErr  = frame_err_q;
    assign ParityErr = par_err_q;
    assign Overrun   = overrun_q;
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core with CLK_DIV=4 (64 clocks per bit).
module tb_uart_fifo_core;
    localparam int DB = 8, CD = 4, FD = 16, PO = 0, BIT = 16 * CD;

    logic       Clk = 1'b0, Rst = 1'b1, Rx = 1'b1, TxWr = 1'b0, RxRd = 1'b0, EchoEn = 1'b0;
    logic [7:0] TxData = 8'h00;
    logic       Tx, TxFull, TxBusy, RxEmpty, FrameErr, ParityErr, Overrun;
    logic [7:0] RxData;
    int n_cmp = 0, n_bad = 0;
    int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
`ifdef UART_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_fifo_core #(.DATA_BITS(DB), .CLK_DIV(CD), .FIFO_DEPTH(FD), .PARITY_ODD(PO)) dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Tx(Tx), .TxData(TxData), .TxWr(TxWr),
        .TxFull(TxFull), .TxBusy(TxBusy), .RxData(RxData), .RxRd(RxRd), .RxEmpty(RxEmpty),
        .EchoEn(EchoEn), .FrameErr(FrameErr), .ParityErr(ParityErr), .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (FrameErr === 1'b1)  fe_cnt <= fe_cnt + 1;
        if (ParityErr === 1'b1) pe_cnt <= pe_cnt + 1;
        if (Overrun === 1'b1)   ov_cnt <= ov_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        Rst = 1'b1; EchoEn = 1'b0; TxWr = 1'b0; RxRd = 1'b0; Rx = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output logic empty_mid);
        Rx = 1'b0;
        repeat (BIT) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            Rx = d[i];
            repeat (BIT) @(negedge Clk);
        end
`ifdef UART_PARITY_EN
        Rx = (^d) ^ (PO != 0) ^ par_flip;
        repeat (BIT) @(negedge Clk);
`endif
        Rx = stop;
        repeat (BIT / 4) @(negedge Clk);
        empty_mid = RxEmpty;
        repeat (BIT - BIT / 4) @(negedge Clk);
        Rx = 1'b1;
    endtask

    task automatic recv_byte(output logic [7:0] d, output logic ok);
        int n;
        d = '0; ok = 1'b0; n = 0;
        while (Tx !== 1'b0 && n < 4000) begin
            @(negedge Clk);
            n++;
        end
        if (Tx !== 1'b0) return;
        repeat (BIT / 2) @(negedge Clk);
        if (Tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge Clk);
            d[i] = Tx;
        end
`ifdef UART_PARITY_EN
        repeat (BIT) @(negedge Clk);
        if (Tx !== ((^d) ^ (PO != 0))) return;
`endif
        repeat (BIT) @(negedge Clk);
        if (Tx !== 1'b1) return;
        ok = 1'b1;
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        n_cmp++; if (Tx !== 1'b1)        begin n_bad++; $display("FAIL reset_tx: got %b want 1", Tx); end
        n_cmp++; if (TxFull !== 1'b0)    begin n_bad++; $display("FAIL reset_txfull: got %b want 0", TxFull); end
        n_cmp++; if (TxBusy !== 1'b0)    begin n_bad++; $display("FAIL reset_txbusy: got %b want 0", TxBusy); end
        n_cmp++; if (RxEmpty !== 1'b1)   begin n_bad++; $display("FAIL reset_rxempty: got %b want 1", RxEmpty); end
        n_cmp++; if (RxData !== 8'h00)   begin n_bad++; $display("FAIL reset_rxdata: got %h want 00", RxData); end
        n_cmp++; if (FrameErr !== 1'b0)  begin n_bad++; $display("FAIL reset_frameerr: got %b want 0", FrameErr); end
        n_cmp++; if (ParityErr !== 1'b0) begin n_bad++; $display("FAIL reset_parityerr: got %b want 0", ParityErr); end
        n_cmp++; if (Overrun !== 1'b0)   begin n_bad++; $display("FAIL reset_overrun: got %b want 0", Overrun); end
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_tx_frame;
        int   lat, nbits;
        logic [10:0] fr;
`ifdef UART_PARITY_EN
        fr = 11'b1_0_1010_0101_0; nbits = 11;
`else
        fr = 11'b0_1_1010_0101_0; nbits = 10;
`endif
        do_reset;
        TxData = 8'hA5; TxWr = 1'b1; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            TxWr = 1'b0;
            if (Tx === 1'b0) begin lat = i; break; end
        end
        n_cmp++; if (lat == 0 || lat > CD + 2) begin n_bad++; $display("FAIL tx_latency: got %0d cycles want 1..%0d", lat, CD + 2); end
        repeat (BIT / 2) @(negedge Clk);
        for (int k = 0; k < nbits; k++) begin
            n_cmp++; if (Tx !== fr[k]) begin n_bad++; $display("FAIL tx_bit%0d: got %b want %b", k, Tx, fr[k]); end
            n_cmp++; if (TxBusy !== 1'b1) begin n_bad++; $display("FAIL tx_busy_bit%0d: got %b want 1", k, TxBusy); end
            repeat (BIT) @(negedge Clk);
        end
        n_cmp++; if (TxBusy !== 1'b0) begin n_bad++; $display("FAIL tx_busy_after: got %b want 0", TxBusy); end
        n_cmp++; if (Tx !== 1'b1)     begin n_bad++; $display("FAIL tx_idle_after: got %b want 1", Tx); end
    endtask

    task automatic test_rx_word;
        logic em;
        int   fe0;
        do_reset;
        send_frame(8'h3C, 1'b1, em);
        n_cmp++; if (em !== 1'b1)      begin n_bad++; $display("FAIL rx_empty_early_stop: got %b want 1", em); end
        n_cmp++; if (RxEmpty !== 1'b0) begin n_bad++; $display("FAIL rx_empty_after: got %b want 0", RxEmpty); end
        n_cmp++; if (RxData !== 8'h3C) begin n_bad++; $display("FAIL rx_data: got %h want 3c", RxData); end
        RxRd = 1'b1;
        @(negedge Clk);
        RxRd = 1'b0;
        n_cmp++; if (RxEmpty !== 1'b1) begin n_bad++; $display("FAIL rx_empty_popped: got %b want 1", RxEmpty); end
        n_cmp++; if (RxData !== 8'h00) begin n_bad++; $display("FAIL rx_data_popped: got %h want 00", RxData); end
        fe0 = fe_cnt;
        Rx = 1'b0;
        repeat (4 * CD) @(negedge Clk);
        Rx = 1'b1;
        repeat (BIT * 12) @(negedge Clk);
        n_cmp++; if (RxEmpty !== 1'b1) begin n_bad++; $display("FAIL rx_glitch_word: got empty=%b want 1", RxEmpty); end
        n_cmp++; if (fe_cnt != fe0)    begin n_bad++; $display("FAIL rx_glitch_ferr: got %0d pulses want 0", fe_cnt - fe0); end
    endtask

    task automatic test_frame_err;
        logic em;
        int   fe0, ov0;
        do_reset;
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h55, 1'b0, em);
        repeat (BIT * 3) @(negedge Clk);
        n_cmp++; if (fe_cnt - fe0 != 1) begin n_bad++; $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt - fe0); end
        n_cmp++; if (RxEmpty !== 1'b1)  begin n_bad++; $display("FAIL frame_err_empty: got %b want 1", RxEmpty); end
        n_cmp++; if (ov_cnt != ov0)     begin n_bad++; $display("FAIL frame_err_overrun: got %0d want 0", ov_cnt - ov0); end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity_err;
        logic em;
        int   pe0, fe0;
        do_reset;
        pe0 = pe_cnt; fe0 = fe_cnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, em);
        par_flip = 1'b0;
        repeat (BIT) @(negedge Clk);
        n_cmp++; if (pe_cnt - pe0 != 1) begin n_bad++; $display("FAIL parity_err_pulses: got %0d want 1", pe_cnt - pe0); end
        n_cmp++; if (fe_cnt != fe0)     begin n_bad++; $display("FAIL parity_frame_err: got %0d want 0", fe_cnt - fe0); end
        n_cmp++; if (RxEmpty !== 1'b1)  begin n_bad++; $display("FAIL parity_empty: got %b want 1", RxEmpty); end
    endtask
`endif

    task automatic test_overrun;
        logic       em;
        logic [7:0] exp;
        int         ov0;
        do_reset;
        ov0 = ov_cnt;
        for (int i = 0; i <= FD; i++) send_frame(8'(8'h20 + 7 * i), 1'b1, em);
        repeat (BIT) @(negedge Clk);
        n_cmp++; if (ov_cnt - ov0 != 1) begin n_bad++; $display("FAIL overrun_pulses: got %0d want 1", ov_cnt - ov0); end
        for (int i = 0; i < FD; i++) begin
            exp = 8'(8'h20 + 7 * i);
            n_cmp++; if (RxEmpty !== 1'b0 || RxData !== exp) begin n_bad++; $display("FAIL overrun_word%0d: got %h (empty %b) want %h", i, RxData, RxEmpty, exp); end
            RxRd = 1'b1;
            @(negedge Clk);
            RxRd = 1'b0;
        end
        n_cmp++; if (RxEmpty !== 1'b1) begin n_bad++; $display("FAIL overrun_drained: got %b want 1", RxEmpty); end
    endtask

    task automatic test_echo;
        logic       em1, em2, ok1, ok2;
        logic [7:0] r1, r2;
        int         ov0, lows;
        do_reset;
        EchoEn = 1'b1;
        TxData = 8'h99; TxWr = 1'b1;
        @(negedge Clk);
        TxWr = 1'b0;
        ov0 = ov_cnt;
        fork
            begin
                send_frame(8'h41, 1'b1, em1);
                send_frame(8'h42, 1'b1, em2);
            end
            begin
                recv_byte(r1, ok1);
                recv_byte(r2, ok2);
            end
        join
        n_cmp++; if (ok1 !== 1'b1 || r1 !== 8'h41) begin n_bad++; $display("FAIL echo_first: got %h ok=%b want 41 ok=1", r1, ok1); end
        n_cmp++; if (ok2 !== 1'b1 || r2 !== 8'h42) begin n_bad++; $display("FAIL echo_second: got %h ok=%b want 42 ok=1", r2, ok2); end
        n_cmp++; if (RxData !== 8'h41) begin n_bad++; $display("FAIL echo_rx0: got %h want 41", RxData); end
        RxRd = 1'b1; @(negedge Clk); RxRd = 1'b0;
        n_cmp++; if (RxData !== 8'h42) begin n_bad++; $display("FAIL echo_rx1: got %h want 42", RxData); end
        RxRd = 1'b1; @(negedge Clk); RxRd = 1'b0;
        n_cmp++; if (RxEmpty !== 1'b1) begin n_bad++; $display("FAIL echo_rx_empty: got %b want 1", RxEmpty); end
        n_cmp++; if (ov_cnt != ov0)    begin n_bad++; $display("FAIL echo_overrun: got %0d want 0", ov_cnt - ov0); end
        TxData = 8'h00; TxWr = 1'b1;
        @(negedge Clk);
        TxWr = 1'b0;
        lows = 0;
        repeat (BIT * 12) begin
            @(negedge Clk);
            if (Tx === 1'b0) lows++;
        end
        n_cmp++; if (lows != 0)       begin n_bad++; $display("FAIL echo_txwr_ignored: got %0d low cycles want 0", lows); end
        n_cmp++; if (TxBusy !== 1'b0) begin n_bad++; $display("FAIL echo_idle: got busy=%b want 0", TxBusy); end
        EchoEn = 1'b0;
    endtask

    task automatic test_tx_full;
        do_reset;
        TxData = 8'h01; TxWr = 1'b1;
        @(negedge Clk);
        TxWr = 1'b0;
        n_cmp++; if (TxFull !== 1'b0) begin n_bad++; $display("FAIL txfull_one: got %b want 0", TxFull); end
        for (int i = 1; i <= FD; i++) begin
            TxData = 8'(i); TxWr = 1'b1;
            @(negedge Clk);
        end
        TxWr = 1'b0;
        n_cmp++; if (TxFull !== 1'b1) begin n_bad++; $display("FAIL txfull_full: got %b want 1", TxFull); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] r;
        logic       ok;
        int         n, lows;
        do_reset;
        TxData = 8'hFF; TxWr = 1'b1; @(negedge Clk);
        TxData = 8'h01; @(negedge Clk);
        TxData = 8'h02; @(negedge Clk);
        TxData = 8'h03; @(negedge Clk);
        TxWr = 1'b0;
        n = 0;
        while (Tx !== 1'b0 && n < 40) begin @(negedge Clk); n++; end
        repeat (20) @(negedge Clk);
        n_cmp++; if (Tx !== 1'b0 || TxBusy !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got tx=%b busy=%b want 0/1", Tx, TxBusy); end
        #3 Rst = 1'b1;
        #1;
        n_cmp++; if (Tx !== 1'b1)      begin n_bad++; $display("FAIL rstmid_tx: got %b want 1", Tx); end
        n_cmp++; if (TxFull !== 1'b0)  begin n_bad++; $display("FAIL rstmid_txfull: got %b want 0", TxFull); end
        n_cmp++; if (TxBusy !== 1'b0)  begin n_bad++; $display("FAIL rstmid_txbusy: got %b want 0", TxBusy); end
        n_cmp++; if (RxEmpty !== 1'b1) begin n_bad++; $display("FAIL rstmid_rxempty: got %b want 1", RxEmpty); end
        @(negedge Clk);
        Rst = 1'b0;
        lows = 0;
        repeat (BIT * 15) begin
            @(negedge Clk);
            if (Tx === 1'b0 || TxBusy === 1'b1) lows++;
        end
        n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", lows); end
        TxData = 8'h5A; TxWr = 1'b1;
        @(negedge Clk);
        TxWr = 1'b0;
        recv_byte(r, ok);
        n_cmp++; if (ok !== 1'b1 || r !== 8'h5A) begin n_bad++; $display("FAIL rstmid_newword: got %h ok=%b want 5a ok=1", r, ok); end
    endtask

    initial begin
        test_reset;
        test_tx_frame;
        test_rx_word;
        test_frame_err;
`ifdef UART_PARITY_EN
        test_parity_err;
`endif
        test_overrun;
        test_echo;
        test_tx_full;
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised successor to the fixed 8-bit, 9600-baud UART top level. It keeps receive, transmit and baud-tick generation in one block, and adds per-direction FIFOs, configurable data width and divider, optional parity, error flags and a runtime echo mode. It sits between the RS232 pins and the user logic, which sees only FIFO push/pop handshakes.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..8, LSB first.
- CLK_DIV, 325: Clk cycles per oversample Tick; the bit period is 16 Ticks (325 gives 9615 baud at 50 MHz).
- FIFO_DEPTH, 16: entries per FIFO, power of two, minimum 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd; used only with UART_PARITY_EN.

Ports:
- Clk  in  1  clock.
- Rst  in  1  asynchronous, active-high reset.
- Rx  in  1  serial input, asynchronous, idle high.
- Tx  out  1  serial output, idle high.
- TxData  in  DATA_BITS  byte to queue for transmit.
- TxWr  in  1  push TxData into the TX FIFO.
- TxFull  out  1  TX FIFO full.
- TxBusy  out  1  transmitter FSM not in IDLE.
- RxData  out  DATA_BITS  head of the RX FIFO (show-ahead), valid while RxEmpty=0.
- RxRd  in  1  pop the RX FIFO.
- RxEmpty  out  1  RX FIFO empty.
- EchoEn  in  1  loop good received words into the TX FIFO.
- FrameErr  out  1  one-cycle pulse: stop bit sampled low.
- ParityErr  out  1  one-cycle pulse: parity mismatch.
- Overrun  out  1  one-cycle pulse: received word dropped because the target FIFO was full.

## Operation
- **Baud generator:** counter runs 0..CLK_DIV-1. Tick is a one-cycle pulse when count==CLK_DIV-1, then the counter wraps to 0. The counter runs continuously.
- **RX synchroniser:** Rx passes through a 2-flop synchroniser. All RX decisions use the synchronised value.
- **RX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.**
  - IDLE: on a low sample at a Tick, go to START with the Tick counter at 0.
  - START: at 8 Ticks, re-sample. If high (glitch), return to IDLE. Otherwise go to DATA.
  - DATA: sample every 16 Ticks, DATA_BITS times, shifting LSB first.
  - PARITY: one sample, present only with the macro.
  - STOP: sample after 16 Ticks, then return to IDLE. Stop bit low → FrameErr pulse, word discarded. Parity mismatch → ParityErr pulse, word discarded. Otherwise push the word into the RX FIFO.
- **RX full:** a push while the RX FIFO is full pulses Overrun and drops the word. FIFO contents are unchanged.
- **Echo:** with EchoEn=1, each good word is also pushed into the TX FIFO. If the TX FIFO is full, Overrun pulses and only the echo copy is dropped. While EchoEn=1, TxWr is ignored.
- **TX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.** Each state lasts 16 Ticks.
  - IDLE: at a Tick with the TX FIFO non-empty, pop the head into the shift register and go to START.
  - Tx = 0 in START, the data bits LSB first in DATA, the parity bit in PARITY, 1 in STOP.
  - At the end of STOP, the next word starts at the next Tick if the FIFO is non-empty.
- **FIFO handshakes:**
  - A push with full=1 is ignored; a pop with empty=1 is ignored.
  - Simultaneous push and pop when neither flag blocks: both occur and the count is unchanged.
  - Push and pop on a full FIFO: pop only. Push and pop on an empty FIFO: push only.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide; the MSB distinguishes full from empty at wrap-around.

## Timing
- **Reset values:** Tx=1, TxFull=0, TxBusy=0, RxEmpty=1, RxData=0, FrameErr=0, ParityErr=0, Overrun=0. Baud counter, FSMs and FIFO pointers all clear to 0 / IDLE.
- **Reset mid-frame:** Tx returns to 1 asynchronously. Both FIFOs are emptied and the partial frame is lost.
- **Flag updates:** TxFull, RxEmpty and RxData update one cycle after the push/pop edge.
- **TX latency:** Tx falls one Clk cycle after the Tick on which IDLE sees a non-empty FIFO. Into an idle transmitter this is at most CLK_DIV+2 cycles after TxWr.
- **RX latency:** RxEmpty deasserts one cycle after the mid-stop-bit sample Tick.
- **Error pulses:** aligned to the same cycle as the push that would have occurred.
- **Frame length:** 16×CLK_DIV×(2+DATA_BITS+P) Clk cycles, where P=1 with the macro and 0 without.

## Configuration
- **UART_PARITY_EN defined:**
  - PARITY state is present in both FSMs.
  - TX sends XOR of the data bits, inverted when PARITY_ODD=1.
  - RX checks parity and drives ParityErr.
- **Undefined:**
  - PARITY state is removed and frames are 8N1-style (DATA_BITS data bits, no parity, one stop bit).
  - ParityErr is tied 0 and PARITY_ODD is unused.

## Test plan
- Reset, then push 0xA5 with CLK_DIV=4: Tx shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each bit 64 cycles. TxBusy=1 throughout, 0 after stop.
- Serial 0x3C into Rx: RxEmpty falls mid-stop, RxData=0x3C, RxRd → RxEmpty=1. A 4-Tick low glitch on Rx produces no word.
- Send FIFO_DEPTH+1 words on Rx without reading: the first 16 words are stored, Overrun pulses once, and the RxData sequence is preserved.
- Stop bit forced low on 0x55: FrameErr pulses one cycle and RxEmpty stays 1. With the macro and PARITY_ODD=0, a wrong parity bit on 0x07 gives a ParityErr pulse.
- EchoEn=1, receive 0x41,0x42: Tx retransmits 0x41 then 0x42 back-to-back, both words are also in the RX FIFO, and TxWr is ignored.
- Assert Rst mid-transmit of 0xFF with 3 words queued: Tx=1 immediately, TxFull=0, and nothing is transmitted after release until a new push.
